// File: rtl/mips_bus_lsu.sv
// mips_bus_lsu: load/store bus master between the CPU datapath and the word-addressed RAM.
// Accepts one CPU memory op at a time, drives a single bus transaction with byte lanes,
// holds it through waitrequest stalls and returns aligned, extended load data.
module mips_bus_lsu #(
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req_valid,
   output logic        cpu_req_ready,
   input  logic [2:0]  cpu_req_op,
   input  logic [31:0] cpu_req_addr,
   input  logic [31:0] cpu_req_wdata,
   output logic        cpu_resp_valid,
   output logic [31:0] cpu_resp_rdata,
   output logic        cpu_resp_error,
   output logic [31:0] address,
   output logic [3:0]  byteenable,
   output logic        write,
   output logic        read,
   output logic [31:0] writedata,
   input  logic        waitrequest,
   input  logic [31:0] readdata
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RDATA, S_DONE} state_t;

   localparam logic [2:0] OP_LW  = 3'd0;
   localparam logic [2:0] OP_LH  = 3'd1;
   localparam logic [2:0] OP_LHU = 3'd2;
   localparam logic [2:0] OP_LB  = 3'd3;
   localparam logic [2:0] OP_LBU = 3'd4;
   localparam logic [2:0] OP_SW  = 3'd5;
   localparam logic [2:0] OP_SH  = 3'd6;
   localparam logic [2:0] OP_SB  = 3'd7;

   // Zero disables the abort; the counter is 16 bits wide.
   localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);

   state_t        state_q;
   logic [2:0]    op_q;
   logic [1:0]    off_q;
   logic [15:0]   stall_q;
   logic          read_q;
   logic          write_q;
   logic [31:0]   address_q;
   logic [3:0]    be_q;
   logic [31:0]   writedata_q;
   logic          resp_valid_q;
   logic          resp_error_q;
   logic [31:0]   resp_rdata_q;

   logic          misalign_d;
   logic          store_d;
   logic [3:0]    be_d;
   logic [31:0]   wdata_d;

   // SW/SH/SB are the three opcodes with bit 2 set and a nonzero low part.
   function automatic logic is_store(input logic [2:0] op);
      return op[2] & (op[1] | op[0]);
   endfunction

   function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] off);
      case (op)
         OP_LW, OP_SW:         return off != 2'b00;
         OP_LH, OP_LHU, OP_SH: return off[0];
         default:              return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] lane_enable(input logic [2:0] op, input logic [1:0] off);
      case (op)
         OP_LW, OP_SW:         return 4'b1111;
         OP_LH, OP_LHU, OP_SH: return off[1] ? 4'b1100 : 4'b0011;
         default:              return 4'b0001 << off;
      endcase
   endfunction

   // Stores replicate the right-justified data across every lane it could land in.
   function automatic logic [31:0] lane_data(input logic [2:0] op, input logic [31:0] wd);
      case (op)
         OP_SW:   return wd;
         OP_SH:   return {2{wd[15:0]}};
         OP_SB:   return {4{wd[7:0]}};
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] load_extend(input logic [2:0] op, input logic [1:0] off,
                                                input logic [31:0] rd);
      logic [7:0]  b;
      logic [15:0] h;
      b = rd[8*off +: 8];
      h = rd[16*off[1] +: 16];
      case (op)
         OP_LW:   return rd;
         OP_LH:   return {{16{h[15]}}, h};
         OP_LHU:  return {16'h0, h};
         OP_LB:   return {{24{b[7]}}, b};
         OP_LBU:  return {24'h0, b};
         default: return 32'h0;
      endcase
   endfunction

   // Decode of the incoming request, used only at the acceptance edge.
   always_comb begin
      misalign_d = is_misaligned(cpu_req_op, cpu_req_addr[1:0]);
      store_d    = is_store(cpu_req_op);
      be_d       = lane_enable(cpu_req_op, cpu_req_addr[1:0]);
      wdata_d    = lane_data(cpu_req_op, cpu_req_wdata);
   end

   // Transaction FSM with registered bus strobes and response fields.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         op_q         <= OP_LW;
         off_q        <= 2'b00;
         stall_q      <= 16'h0;
         read_q       <= 1'b0;
         write_q      <= 1'b0;
         address_q    <= 32'h0;
         be_q         <= 4'h0;
         writedata_q  <= 32'h0;
         resp_valid_q <= 1'b0;
         resp_error_q <= 1'b0;
         resp_rdata_q <= 32'h0;
      end else begin
         resp_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (cpu_req_valid) begin
                  op_q  <= cpu_req_op;
                  off_q <= cpu_req_addr[1:0];
                  if (misalign_d) begin
                     // No bus cycle: answer with an error straight away.
                     resp_valid_q <= 1'b1;
                     resp_error_q <= 1'b1;
                     resp_rdata_q <= 32'h0;
                     state_q      <= S_DONE;
                  end else begin
                     address_q   <= {cpu_req_addr[31:2], 2'b00};
                     be_q        <= be_d;
                     writedata_q <= wdata_d;
                     read_q      <= ~store_d;
                     write_q     <= store_d;
                     stall_q     <= 16'h0;
                     state_q     <= S_REQ;
                  end
               end
            end
            S_REQ: begin
               if (!waitrequest) begin
                  read_q  <= 1'b0;
                  write_q <= 1'b0;
                  if (is_store(op_q)) begin
                     resp_valid_q <= 1'b1;
                     resp_error_q <= 1'b0;
                     resp_rdata_q <= 32'h0;
                     state_q      <= S_DONE;
                  end else begin
                     state_q <= S_RDATA;
                  end
               end else if ((TO_LIM != 16'h0) && ((stall_q + 16'h1) >= TO_LIM)) begin
                  read_q       <= 1'b0;
                  write_q      <= 1'b0;
                  resp_valid_q <= 1'b1;
                  resp_error_q <= 1'b1;
                  resp_rdata_q <= 32'h0;
                  state_q      <= S_DONE;
               end else if (stall_q != 16'hFFFF) begin
                  stall_q <= stall_q + 16'h1;
               end
            end
            S_RDATA: begin
               // Slave readdata is registered, so it is valid in this cycle.
               resp_valid_q <= 1'b1;
               resp_error_q <= 1'b0;
               resp_rdata_q <= load_extend(op_q, off_q, readdata);
               state_q      <= S_DONE;
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign cpu_req_ready  = (state_q == S_IDLE) && !reset;
   assign cpu_resp_valid = resp_valid_q;
   assign cpu_resp_error = resp_error_q;
   assign cpu_resp_rdata = resp_rdata_q;
   assign address        = address_q;
   assign byteenable     = be_q;
   assign write          = write_q;
   assign read           = read_q;
   assign writedata      = writedata_q;

endmodule

// File: tb/tb_mips_bus_lsu.sv
// tb_mips_bus_lsu: table vectors, randomized ops against a byte-level reference model,
// plus hand sequences for timeout abort and reset in the middle of a read.
module tb_mips_bus_lsu;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cpu_req_valid = 1'b0;
   logic [2:0]  cpu_req_op = 3'd0;
   logic [31:0] cpu_req_addr = 32'h0;
   logic [31:0] cpu_req_wdata = 32'h0;
   logic        waitrequest = 1'b0;
   logic [31:0] readdata = 32'h0;

   logic        cpu_req_ready, cpu_resp_valid, cpu_resp_error, write, read;
   logic [31:0] cpu_resp_rdata, address, writedata;
   logic [3:0]  byteenable;

   logic        t_ready, t_resp_valid, t_resp_error, t_write, t_read;
   logic [31:0] t_resp_rdata, t_address, t_writedata;
   logic [3:0]  t_byteenable;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mips_bus_lsu #(.TIMEOUT_CYCLES(0)) dut (
      .clk(clk), .reset(reset),
      .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
      .cpu_req_op(cpu_req_op), .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
      .cpu_resp_valid(cpu_resp_valid), .cpu_resp_rdata(cpu_resp_rdata), .cpu_resp_error(cpu_resp_error),
      .address(address), .byteenable(byteenable), .write(write), .read(read),
      .writedata(writedata), .waitrequest(waitrequest), .readdata(readdata)
   );

   mips_bus_lsu #(.TIMEOUT_CYCLES(2)) dut_to (
      .clk(clk), .reset(reset),
      .cpu_req_valid(cpu_req_valid), .cpu_req_ready(t_ready),
      .cpu_req_op(cpu_req_op), .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
      .cpu_resp_valid(t_resp_valid), .cpu_resp_rdata(t_resp_rdata), .cpu_resp_error(t_resp_error),
      .address(t_address), .byteenable(t_byteenable), .write(t_write), .read(t_read),
      .writedata(t_writedata), .waitrequest(waitrequest), .readdata(readdata)
   );

   typedef struct {
      logic [2:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdword;
      int          nwait;
      logic [31:0] e_rdata;
      logic        e_err;
      int          e_lat;
      int          e_nstb;
      logic [3:0]  e_be;
      logic [31:0] e_addr;
      logic [31:0] e_wd;
   } vec_t;

   typedef struct {
      logic        ready;
      int          lat;
      int          nresp;
      logic [31:0] rdata;
      logic        err;
      int          nrd;
      int          nwr;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wd;
      logic        stable;
   } obs_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: an op touches `size` bytes starting at byte offset addr%4.
   function automatic void model(input logic [2:0] op, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rdword, input int nwait,
                                 output logic [31:0] e_rdata, output logic e_err, output int e_lat,
                                 output int e_nstb, output logic [3:0] e_be, output logic [31:0] e_addr,
                                 output logic [31:0] e_wd, output logic e_store);
      int size, off;
      logic [31:0] mask, val;
      case (op)
         3'd0, 3'd5:       size = 4;
         3'd1, 3'd2, 3'd6: size = 2;
         default:          size = 1;
      endcase
      e_store = (op >= 3'd5);
      off     = int'(addr % 4);
      e_err   = (addr % size) != 0;
      e_be    = 4'(((1 << size) - 1) << off);
      e_addr  = addr - 32'(off);
      for (int i = 0; i < 4; i++) e_wd[8*i +: 8] = wdata[8*(i % size) +: 8];
      mask = (size == 4) ? 32'hFFFF_FFFF : 32'((1 << (8 * size)) - 1);
      val  = (rdword >> (8 * off)) & mask;
      if ((op == 3'd1 || op == 3'd3) && val[8*size-1]) val = val | ~mask;
      e_rdata = (e_err || e_store) ? 32'h0 : val;
      e_lat   = e_err ? 1 : ((e_store ? 2 : 3) + nwait);
      e_nstb  = e_err ? 0 : 1 + nwait;
   endfunction

   // Starts #1 after a posedge with the DUT idle; ends #1 after a posedge, idle again.
   task automatic run_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdword, input int nwait, output obs_t o);
      int  waits_left;
      logic acc_rd;
      o.ready = 1'b0; o.lat = -1; o.nresp = 0; o.rdata = 32'h0; o.err = 1'b0;
      o.nrd = 0; o.nwr = 0; o.be = 4'h0; o.addr = 32'h0; o.wd = 32'h0; o.stable = 1'b1;
      cpu_req_op = op; cpu_req_addr = addr; cpu_req_wdata = wdata; cpu_req_valid = 1'b1;
      waitrequest = 1'b0; readdata = $urandom;
      @(negedge clk);
      o.ready = cpu_req_ready;
      @(posedge clk); #1;
      cpu_req_valid = 1'b0;
      cpu_req_op = 3'($urandom_range(0, 7)); cpu_req_addr = $urandom; cpu_req_wdata = $urandom;
      waits_left = nwait;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         waitrequest = (waits_left > 0);
         @(negedge clk);
         acc_rd = 1'b0;
         if (read || write) begin
            if (o.nrd + o.nwr == 0) begin
               o.be = byteenable; o.addr = address; o.wd = writedata;
            end else if (byteenable !== o.be || address !== o.addr || writedata !== o.wd) begin
               o.stable = 1'b0;
            end
            if (read) o.nrd++;
            if (write) o.nwr++;
            if (waitrequest) waits_left--;
            else acc_rd = read;
         end
         if (cpu_resp_valid) begin
            o.nresp++;
            if (o.lat < 0) begin
               o.lat = cyc; o.rdata = cpu_resp_rdata; o.err = cpu_resp_error;
            end
         end
         @(posedge clk); #1;
         readdata = acc_rd ? rdword : $urandom;
         if (o.lat >= 0 && cyc > o.lat) break;
      end
      waitrequest = 1'b0;
   endtask

   task automatic check_obs(input string tag, input obs_t o, input logic [31:0] e_rdata, input logic e_err,
                            input int e_lat, input int e_nstb, input logic [3:0] e_be,
                            input logic [31:0] e_addr, input logic [31:0] e_wd, input logic e_store);
      chk({tag, " ready"}, 32'(o.ready), 32'd1);
      chk({tag, " latency"}, 32'(o.lat), 32'(e_lat));
      chk({tag, " resp_pulses"}, 32'(o.nresp), 32'd1);
      chk({tag, " rdata"}, o.rdata, e_rdata);
      chk({tag, " error"}, 32'(o.err), 32'(e_err));
      chk({tag, " read_cycles"}, 32'(o.nrd), e_store ? 32'd0 : 32'(e_nstb));
      chk({tag, " write_cycles"}, 32'(o.nwr), e_store ? 32'(e_nstb) : 32'd0);
      if (e_nstb > 0) begin
         chk({tag, " byteenable"}, 32'(o.be), 32'(e_be));
         chk({tag, " address"}, o.addr, e_addr);
         chk({tag, " stable"}, 32'(o.stable), 32'd1);
         if (e_store) chk({tag, " writedata"}, o.wd, e_wd);
      end
   endtask

   initial begin
      vec_t        vt[$];
      obs_t        o;
      logic [31:0] m_rdata, m_addr, m_wd, rd;
      logic        m_err, m_store;
      logic [3:0]  m_be;
      logic [2:0]  op;
      int          m_lat, m_nstb, nw, t_lat, t_nrd;
      logic        t_err;
      logic [31:0] t_rdata;
      logic        saw_resp;

      //        op    addr          wdata         rdword        nw rdata         err lat nstb be       addr          wd
      vt.push_back('{3'd5, 32'h100, 32'hDEADBEEF, 32'h0,        0, 32'h0,        0, 2, 1, 4'b1111, 32'h100, 32'hDEADBEEF});
      vt.push_back('{3'd3, 32'h103, 32'h0,        32'h80FF1234, 0, 32'hFFFFFF80, 0, 3, 1, 4'b1000, 32'h100, 32'h0});
      vt.push_back('{3'd4, 32'h103, 32'h0,        32'h80FF1234, 0, 32'h00000080, 0, 3, 1, 4'b1000, 32'h100, 32'h0});
      vt.push_back('{3'd2, 32'h102, 32'h0,        32'h80FF1234, 0, 32'h000080FF, 0, 3, 1, 4'b1100, 32'h100, 32'h0});
      vt.push_back('{3'd0, 32'h102, 32'h0,        32'h0,        0, 32'h0,        1, 1, 0, 4'b0000, 32'h0,   32'h0});
      vt.push_back('{3'd6, 32'h106, 32'h0000ABCD, 32'h0,        0, 32'h0,        0, 2, 1, 4'b1100, 32'h104, 32'hABCDABCD});
      vt.push_back('{3'd7, 32'h105, 32'h00000077, 32'h0,        0, 32'h0,        0, 2, 1, 4'b0010, 32'h104, 32'h77777777});
      vt.push_back('{3'd6, 32'h101, 32'h0000ABCD, 32'h0,        0, 32'h0,        1, 1, 0, 4'b0000, 32'h0,   32'h0});
      vt.push_back('{3'd0, 32'h200, 32'h0,        32'h12345678, 3, 32'h12345678, 0, 6, 4, 4'b1111, 32'h200, 32'h0});
      vt.push_back('{3'd5, 32'h204, 32'hCAFEF00D, 32'h0,        0, 32'h0,        0, 2, 1, 4'b1111, 32'h204, 32'hCAFEF00D});
      vt.push_back('{3'd1, 32'h102, 32'h0,        32'h80FF1234, 0, 32'hFFFF80FF, 0, 3, 1, 4'b1100, 32'h100, 32'h0});
      vt.push_back('{3'd1, 32'h100, 32'h0,        32'h80FF1234, 1, 32'h00001234, 0, 4, 2, 4'b0011, 32'h100, 32'h0});
      vt.push_back('{3'd3, 32'h101, 32'h0,        32'h80FF1234, 0, 32'h00000012, 0, 3, 1, 4'b0010, 32'h100, 32'h0});
      vt.push_back('{3'd7, 32'h10B, 32'h123456AB, 32'h0,        1, 32'h0,        0, 3, 2, 4'b1000, 32'h108, 32'hABABABAB});
      vt.push_back('{3'd2, 32'h101, 32'h0,        32'h0,        0, 32'h0,        1, 1, 0, 4'b0000, 32'h0,   32'h0});

      // Reset state.
      #2 reset = 1'b1;
      #2;
      chk("rst read", 32'(read), 32'd0);
      chk("rst write", 32'(write), 32'd0);
      chk("rst resp_valid", 32'(cpu_resp_valid), 32'd0);
      chk("rst resp_error", 32'(cpu_resp_error), 32'd0);
      chk("rst resp_rdata", cpu_resp_rdata, 32'h0);
      chk("rst address", address, 32'h0);
      chk("rst byteenable", 32'(byteenable), 32'h0);
      chk("rst writedata", writedata, 32'h0);
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("rst ready_after", 32'(cpu_req_ready), 32'd1);
      @(posedge clk); #1;

      // Table vectors.
      for (int i = 0; i < vt.size(); i++) begin
         run_op(vt[i].op, vt[i].addr, vt[i].wdata, vt[i].rdword, vt[i].nwait, o);
         check_obs($sformatf("vec%0d", i), o, vt[i].e_rdata, vt[i].e_err, vt[i].e_lat, vt[i].e_nstb,
                   vt[i].e_be, vt[i].e_addr, vt[i].e_wd, vt[i].op >= 3'd5);
      end

      // Random ops against the reference model.
      for (int i = 0; i < 60; i++) begin
         op = 3'($urandom_range(0, 7));
         m_addr = $urandom;
         m_wd = $urandom;
         rd = $urandom;
         nw = $urandom_range(0, 3);
         run_op(op, m_addr, m_wd, rd, nw, o);
         model(op, m_addr, m_wd, rd, nw, m_rdata, m_err, m_lat, m_nstb, m_be, m_addr, m_wd, m_store);
         check_obs($sformatf("rnd%0d", i), o, m_rdata, m_err, m_lat, m_nstb, m_be, m_addr, m_wd, m_store);
      end

      // Timeout: waitrequest stuck high, abort after two stall cycles on the TIMEOUT_CYCLES=2 instance.
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      cpu_req_op = 3'd0; cpu_req_addr = 32'h300; cpu_req_wdata = 32'h0;
      cpu_req_valid = 1'b1; waitrequest = 1'b1;
      @(posedge clk); #1;
      cpu_req_valid = 1'b0;
      t_lat = -1; t_nrd = 0; t_err = 1'b0; t_rdata = 32'hFFFF_FFFF;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (t_read) t_nrd++;
         if (t_resp_valid && t_lat < 0) begin
            t_lat = c; t_err = t_resp_error; t_rdata = t_resp_rdata;
         end
         @(posedge clk); #1;
      end
      chk("timeout latency", 32'(t_lat), 32'd3);
      chk("timeout error", 32'(t_err), 32'd1);
      chk("timeout rdata", t_rdata, 32'h0);
      chk("timeout read_cycles", 32'(t_nrd), 32'd2);
      chk("no_timeout read_held", 32'(read), 32'd1);
      chk("no_timeout no_resp", 32'(cpu_resp_valid), 32'd0);

      // Reset in the middle of a stalled read: strobe must drop before any clock edge.
      #3 reset = 1'b1;
      #1;
      chk("midrst read_drop", 32'(read), 32'd0);
      chk("midrst address", address, 32'h0);
      saw_resp = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         if (cpu_resp_valid) saw_resp = 1'b1;
      end
      @(posedge clk); #1;
      reset = 1'b0;
      waitrequest = 1'b0;
      @(negedge clk);
      if (cpu_resp_valid) saw_resp = 1'b1;
      chk("midrst no_resp", 32'(saw_resp), 32'd0);
      chk("midrst ready", 32'(cpu_req_ready), 32'd1);
      @(posedge clk); #1;
      run_op(3'd0, 32'h400, 32'h0, 32'h0BADF00D, 0, o);
      check_obs("post_reset_lw", o, 32'h0BADF00D, 1'b0, 3, 1, 4'b1111, 32'h400, 32'h0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
